// File: rtl/aes_pkg.sv
// Shared types, constants and the GF(2^8) doubling helper for the AES-128 key schedule.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      READY
   } state_t;

   localparam int         NB         = 4;
   localparam logic [7:0] RCON_INIT  = 8'h01;
   localparam logic [7:0] XTIME_POLY = 8'h1b;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return b[7] ? ({b[6:0], 1'b0} ^ XTIME_POLY) : {b[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box; byte k of the table sits at bits {~k,3'b000} +: 8.
module aes_sbox (
   input  logic [7:0] value,
   output logic [7:0] result
);

   localparam logic [2047:0] TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign result = TABLE[{~value, 3'b000} +: 8];

endmodule

// File: rtl/key_schedule_sequencer.sv
// AES-128 key expansion: one full round key per cycle into an nr+1 slot register file,
// with a registered single-slot read port that refuses reads until all slots are valid.
//
// state  | meaning
// IDLE   | no valid key schedule; waiting for a key
// EXPAND | writing slot[round] from slot[round-1] each cycle
// READY  | all slots valid; reads served, a new key restarts expansion
module key_schedule_sequencer
   import aes_pkg::*;
#(
   parameter int nk = 4,
   parameter int nr = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   input  logic [127:0] key,
   output logic         key_ready,
   output logic         busy,
   output logic         done,
   input  logic         rk_rd,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk,
   output logic         rk_valid,
   output logic         rk_err
);

   localparam logic [3:0] LAST = 4'(nr);

   state_t       state, next_state;
   logic [3:0]   round;
   logic [7:0]   rcon;
   logic [127:0] slots [nr+1];

   logic         accept;
   logic         read_ok;
   logic [127:0] prev_key, next_key;
   logic [31:0]  rot_word, sub_word;
   logic [31:0]  prev_w [NB];
   logic [31:0]  new_w  [NB];

   assign key_ready = (state != EXPAND);
   assign busy      = (state == EXPAND);
   assign done      = (state == READY);
   assign accept    = key_valid && key_ready;
   // A key load in the same cycle as a read invalidates the schedule, so the read is refused.
   assign read_ok   = (state == READY) && !accept && (rk_idx <= LAST);

   assign prev_key = slots[round - 4'd1];
   assign rot_word = {prev_w[NB-1][23:0], prev_w[NB-1][31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .value  (rot_word[8*i +: 8]),
         .result (sub_word[8*i +: 8])
      );
   end

   always_comb begin
      next_key = '0;
      for (int j = 0; j < NB; j++) begin
         prev_w[j] = prev_key[127-32*j -: 32];
      end
      new_w    = prev_w;
      new_w[0] = prev_w[0] ^ sub_word ^ {rcon, 24'h0};
      for (int j = 1; j < nk; j++) begin
         new_w[j] = prev_w[j] ^ new_w[j-1];
      end
      for (int j = 0; j < NB; j++) begin
         next_key[127-32*j -: 32] = new_w[j];
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = EXPAND;
         EXPAND:  if (round == LAST) next_state = READY;
         READY:   if (accept) next_state = EXPAND;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         round    <= '0;
         rcon     <= RCON_INIT;
         rk       <= '0;
         rk_valid <= 1'b0;
         rk_err   <= 1'b0;
      end else begin
         state    <= next_state;
         rk_valid <= rk_rd;
         rk_err   <= rk_rd && !read_ok;
         if (rk_rd) rk <= read_ok ? slots[rk_idx] : '0;
         if (accept) begin
            round <= 4'd1;
            rcon  <= RCON_INIT;
         end else if (state == EXPAND) begin
            round <= round + 4'd1;
            rcon  <= xtime(rcon);
         end
      end
   end

   // Slot storage is deliberately not reset; an aborted schedule is never readable anyway.
   always_ff @(posedge clk) begin
      if (accept) slots[0] <= key;
      else if (state == EXPAND) slots[round] <= next_key;
   end

endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Scoreboard bench for key_schedule_sequencer: reads are predicted from an arithmetic AES
// key-expansion model (S-box derived from GF(2^8) inversion) and checked by a separate monitor.
module tb_key_schedule_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_valid;
   logic [127:0] key;
   logic         key_ready, busy, done;
   logic         rk_rd;
   logic [3:0]   rk_idx;
   logic [127:0] rk;
   logic         rk_valid, rk_err;

   always #5 clk = ~clk;

   key_schedule_sequencer #(.nk(4), .nr(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key       (key),
      .key_ready (key_ready),
      .busy      (busy),
      .done      (done),
      .rk_rd     (rk_rd),
      .rk_idx    (rk_idx),
      .rk        (rk),
      .rk_valid  (rk_valid),
      .rk_err    (rk_err)
   );

   typedef struct packed {
      logic [127:0] data;
      logic         err;
   } resp_t;

   localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A_RK5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
   localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [7:0] RCON_SEQ [10] =
      '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   resp_t        exp_q [$];
   resp_t        got;
   int           checks = 0;
   int           errors = 0;
   logic [127:0] model_rks [11];
   int           m_state;   // 0 idle, 1 expanding, 2 ready
   int           m_cnt;
   logic [127:0] last_rk;
   logic         ovr;
   logic [127:0] ovr_val;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_m(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      logic [7:0] p = a;
      logic [7:0] s;
      // a^254 is the multiplicative inverse (and maps 0 to 0)
      for (int k = 1; k < 8; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      if (a == 8'h00) r = 8'h00;
      s = r ^ 8'h63;
      for (int n = 1; n < 5; n++) s = s ^ ((r << n) | (r >> (8 - n)));
      return s;
   endfunction

   task automatic build_model(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
            t = t ^ {rc, 24'h0};
            rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) model_rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Applies current inputs for one clock: predicts the read response and the model state.
   task automatic tick();
      logic acc;
      acc = key_valid && (m_state != 1);
      if (m_state == 1) chk("rcon", 128'(dut.rcon), 128'(RCON_SEQ[m_cnt]));
      if (rk_rd) begin
         if (ovr)
            exp_q.push_back('{data: ovr_val, err: 1'b0});
         else if (m_state == 2 && !acc && rk_idx <= 4'd10)
            exp_q.push_back('{data: model_rks[rk_idx], err: 1'b0});
         else
            exp_q.push_back('{data: 128'h0, err: 1'b1});
      end
      if (acc) begin
         build_model(key);
         m_state = 1;
         m_cnt   = 0;
      end else if (m_state == 1) begin
         m_cnt++;
         if (m_cnt == 10) m_state = 2;
      end
      @(posedge clk);
      #1;
      chk("done", 128'(done), 128'(m_state == 2));
      chk("busy", 128'(busy), 128'(m_state == 1));
      chk("key_ready", 128'(key_ready), 128'(m_state != 1));
   endtask

   task automatic rd_const(input logic [3:0] idx, input logic [127:0] val);
      rk_rd   = 1'b1;
      rk_idx  = idx;
      ovr     = 1'b1;
      ovr_val = val;
      tick();
      rk_rd = 1'b0;
      ovr   = 1'b0;
   endtask

   task automatic load(input logic [127:0] k);
      key       = k;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic run_to_ready();
      int n = 0;
      while (m_state != 2 && n < 20) begin
         tick();
         n++;
      end
      chk("expand_bound", 128'(m_state == 2), 128'd1);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rk_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rk_valid_unexpected actual=1 required=0 at %0t", $time);
            end else begin
               got = exp_q.pop_front();
               chk("rk_data", rk, got.data);
               chk("rk_err", 128'(rk_err), 128'(got.err));
               last_rk = got.data;
            end
         end else begin
            chk("rk_err_idle", 128'(rk_err), 128'd0);
            chk("rk_hold", rk, last_rk);
         end
      end
   end

   initial begin
      rst       = 1'b1;
      key_valid = 1'b0;
      key       = '0;
      rk_rd     = 1'b0;
      rk_idx    = '0;
      ovr       = 1'b0;
      ovr_val   = '0;
      m_state   = 0;
      m_cnt     = 0;
      last_rk   = '0;
      #3;
      chk("rst_key_ready", 128'(key_ready), 128'd1);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_rk", rk, 128'd0);
      chk("rst_rk_valid", 128'(rk_valid), 128'd0);
      chk("rst_rk_err", 128'(rk_err), 128'd0);
      chk("rst_round", 128'(dut.round), 128'd0);
      chk("rst_rcon", 128'(dut.rcon), 128'h01);
      #9;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // read in IDLE is refused
      rk_rd = 1'b1; rk_idx = 4'd0; tick(); rk_rd = 1'b0;

      // FIPS-197 key, a read during EXPAND, then directed reads
      load(KEY_A);
      rk_rd = 1'b1; rk_idx = 4'd3; tick(); rk_rd = 1'b0;
      run_to_ready();
      rd_const(4'd0, KEY_A);
      rd_const(4'd1, A_RK1);
      rd_const(4'd5, A_RK5);
      rd_const(4'd10, A_RK10);
      rk_rd = 1'b1; rk_idx = 4'd11; tick();
      rk_idx = 4'd15; tick();
      rk_idx = 4'd7; tick(); rk_rd = 1'b0;
      tick();

      // key load and read together in READY: load wins, read refused
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_valid = 1'b1; rk_rd = 1'b1; rk_idx = 4'd2;
      tick();
      key_valid = 1'b0; rk_rd = 1'b0;
      key_valid = 1'b1; key = KEY_B; tick(); key_valid = 1'b0;   // ignored during EXPAND
      run_to_ready();
      rk_rd = 1'b1; rk_idx = 4'd9; tick(); rk_rd = 1'b0;

      // reset in the middle of expansion, then a fresh key
      load(KEY_A);
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_done", 128'(done), 128'd0);
      chk("abort_key_ready", 128'(key_ready), 128'd1);
      chk("abort_rk_valid", 128'(rk_valid), 128'd0);
      chk("abort_rk", rk, 128'd0);
      m_state = 0;
      m_cnt   = 0;
      last_rk = '0;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_idle_done", 128'(done), 128'd0);
      chk("abort_idle_busy", 128'(busy), 128'd0);
      rk_rd = 1'b1; rk_idx = 4'd10; tick(); rk_rd = 1'b0;
      load(KEY_B);
      run_to_ready();
      rd_const(4'd10, B_RK10);
      rd_const(4'd0, KEY_B);

      // random traffic against the model
      repeat (400) begin
         key_valid = ($urandom_range(0, 15) == 0);
         key       = {$urandom(), $urandom(), $urandom(), $urandom()};
         rk_rd     = 1'($urandom_range(0, 1));
         rk_idx    = 4'($urandom_range(0, 15));
         tick();
      end
      key_valid = 1'b0;
      rk_rd     = 1'b0;
      tick();
      tick();
      chk("drain", 128'(exp_q.size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
